xi_gather_reader: RTL
=====================

XI_GATHER_READER -- requirements
Module: xi_gather_reader

Interface
REQ-001 SHALL have parameter X_BASE_ADDR, default 32'h40000000: byte base address of the X vector.
REQ-002 SHALL have parameter MAX_OUTST, default 4: maximum number of AR requests in flight; legal values are powers of 2 from 1 to 16.
REQ-003 SHALL have parameter LEN_W, default 32: width of length and of the element counters.
REQ-004 clk  in  1  clock; all logic is rising-edge.
REQ-005 rstn  in  1  reset; synchronous, active-low.
REQ-006 start  in  1  one-cycle pulse that begins a gather job.
REQ-007 length  in  LEN_W  number of elements in the job; sampled at start.
REQ-008 mode  in  2  element width; 0=16b, 1=32b, 2=64b, 3 reserved (treated as 2); sampled at start.
REQ-009 busy  out  1  job active.
REQ-010 done  out  1  one-cycle pulse when the job completes.
REQ-011 err  out  1  sticky AXI response error flag (see REQ-030).
REQ-012 col_valid  in  1  column-index stream valid.
REQ-013 col_ready  out  1  column-index stream ready.
REQ-014 col_idx  in  32  element index into X.
REQ-015 m_axi_araddr  out  32  read address.
REQ-016 m_axi_arlen  out  8  burst length; constant 0 (single beat).
REQ-017 m_axi_arsize  out  3  transfer size; equals latched mode+1.
REQ-018 m_axi_arvalid  out  1  AR valid.
REQ-019 m_axi_arready  in  1  AR ready.
REQ-020 m_axi_rdata  in  64  read data.
REQ-021 m_axi_rresp  in  2  read response.
REQ-022 m_axi_rvalid  in  1  R valid.
REQ-023 m_axi_rready  out  1  R ready.
REQ-024 xi_valid / xi_ready / xi_data  out / in / out  1 / 1 / 64  gathered element stream, zero-extended to 64b.

Function
REQ-025 SHALL treat start while busy=1 as ignored; start while idle latches length and mode and sets busy=1 on the next cycle; start with length=0 SHALL pulse done the next cycle, issue no AR, and leave busy=0.
REQ-026 SHALL drive m_axi_araddr = X_BASE_ADDR + (col_idx << (mode_l+1)), truncated to 32b; m_axi_arvalid = busy & col_valid & (credit<MAX_OUTST) & (issued<length_l); col_ready = m_axi_arvalid & m_axi_arready; each index is consumed in the same cycle its AR is accepted.
REQ-027 SHALL keep credit = ARs accepted minus xi handshakes; a simultaneous AR accept and xi handshake SHALL leave credit unchanged; credit never exceeds MAX_OUTST.
REQ-028 SHALL push araddr[2:0] into an offset FIFO (depth MAX_OUTST) on each AR accept; on each R handshake it SHALL pop the offset and push (rdata >> 8*offset) masked to the element width into a data FIFO (depth MAX_OUTST); responses are in order.
REQ-029 SHALL drive m_axi_rready = busy (always accepted, because credits reserve space); xi_valid = data FIFO not empty; xi_data = FIFO head; a FIFO written and read in the same cycle keeps its count.
REQ-030 SHALL pulse done in the cycle after the xi handshake that delivers element length_l, and SHALL clear busy at the same time; from start to done, elements emerge in col_idx order.
REQ-031 SHALL hold outputs stable while xi_valid=1 and xi_ready=0 (no data loss, no reordering).

Reset
REQ-032 On rstn=0 at a clock edge, SHALL set busy, done, err, credit and counters to 0, empty both FIFOs, and drive arvalid, rready, xi_valid and col_ready to 0; reset mid-job SHALL abandon the job silently; the system resets the AXI slave together with this block.

Configuration
REQ-033 With XI_GATHER_RESP_ERR_EN defined, err SHALL be set on any R handshake with rresp!=0 and SHALL stay set until the next accepted start or reset, and the data is still delivered; without the macro, err SHALL be tied 0 and rresp SHALL be ignored.

Verification
REQ-034 mode=1, length=3, idx {0,5,2}, slave latency 1 -> araddr 0x40000000/0x40000014/0x40000008, arsize 2, xi_data equals the three words, done once.
REQ-035 mode=0, idx 3 (byte offset 6), rdata 0x1234_0000_0000_0000 -> xi_data 0x1234; mode=2, idx 1 -> araddr 0x40000008, arsize 3, full 64b passed.
REQ-036 MAX_OUTST=4, slave holds R for 20 cycles, xi_ready=1 -> exactly 4 ARs issued, then arvalid stays low until the first xi handshake.
REQ-037 xi_ready=0 for 30 cycles mid-job -> credit saturates, no AR issued, no element lost or reordered after release.
REQ-038 length=0 -> done 1 cycle after start, no AR; start while busy -> ignored; rstn low mid-job -> all outputs 0 next cycle; a new job after reset runs correctly.
REQ-039 XI_GATHER_RESP_ERR_EN defined, one response with rresp=2 -> err=1 until next start; macro undefined -> err stays 0.

Source files
------------

// File: rtl/xi_gather_if.sv
// xi_gather_if: column-index stream, single-beat AXI read channels and gathered element stream
interface xi_gather_if;
  logic        col_valid;
  logic        col_ready;
  logic [31:0] col_idx;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [63:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic        xi_valid;
  logic        xi_ready;
  logic [63:0] xi_data;
  modport master (
    input  col_valid, col_idx, m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid, xi_ready,
    output col_ready, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arvalid, m_axi_rready, xi_valid, xi_data
  );
  modport slave (
    output col_valid, col_idx, m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid, xi_ready,
    input  col_ready, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arvalid, m_axi_rready, xi_valid, xi_data
  );
endinterface

// File: rtl/xi_gather_reader.sv
// xi_gather_reader: gathers X[col_idx] with single-beat AXI reads into an in-order element stream.
// Optional XI_GATHER_RESP_ERR_EN: sticky err on any non-OKAY read response.
module xi_gather_reader #(
  parameter logic [31:0] X_BASE_ADDR = 32'h40000000,
  parameter int          MAX_OUTST   = 4,
  parameter int          LEN_W       = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [LEN_W-1:0] length,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic             err,
  xi_gather_if.master      bus
);
  localparam int PW = MAX_OUTST > 1 ? $clog2(MAX_OUTST) : 1;
  localparam int CW = $clog2(MAX_OUTST + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [LEN_W-1:0] length_l, issued, delivered;
  logic [1:0] msz;
  logic [CW-1:0] credit, dcnt;
  logic [PW-1:0] owr, ord, dwr, drd;
  logic [2:0] ofs_mem [MAX_OUTST];
  logic [63:0] dat_mem [MAX_OUTST];
  logic start_ok, last, ar_fire, r_fire, xi_fire;
  logic [63:0] shifted, elem;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(MAX_OUTST - 1) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    state_d = state_q;
    start_ok = state_q == IDLE && start;
    last = xi_fire && delivered == length_l - 1'b1;
    if (start_ok && length != '0) state_d = RUN;
    else if (state_q == RUN && last) state_d = IDLE;
  end
  assign busy = state_q == RUN;
  // credits reserve a data FIFO slot per AR, so R can always be accepted while busy
  assign bus.m_axi_arvalid = busy && bus.col_valid && credit < CW'(MAX_OUTST) && issued < length_l;
  assign ar_fire = bus.m_axi_arvalid && bus.m_axi_arready;
  assign bus.col_ready = ar_fire;
  assign bus.m_axi_araddr = X_BASE_ADDR + (bus.col_idx << (msz + 2'd1));
  assign bus.m_axi_arlen = 8'd0;
  assign bus.m_axi_arsize = {1'b0, msz} + 3'd1;
  assign bus.m_axi_rready = busy;
  assign r_fire = busy && bus.m_axi_rvalid;
  assign bus.xi_valid = dcnt != '0;
  assign bus.xi_data = dat_mem[drd];
  assign xi_fire = bus.xi_valid && bus.xi_ready;
  assign shifted = bus.m_axi_rdata >> {ofs_mem[ord], 3'b000};
  assign elem = msz == 2'd0 ? {48'd0, shifted[15:0]} : msz == 2'd1 ? {32'd0, shifted[31:0]} : shifted;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      done <= 1'b0;
      length_l <= '0;
      msz <= '0;
      issued <= '0;
      delivered <= '0;
      credit <= '0;
      dcnt <= '0;
      owr <= '0;
      ord <= '0;
      dwr <= '0;
      drd <= '0;
    end else begin
      state_q <= state_d;
      done <= (start_ok && length == '0) || (busy && last);
      if (start_ok) begin
        length_l <= length;
        msz <= mode == 2'd3 ? 2'd2 : mode;
        issued <= '0;
        delivered <= '0;
      end else begin
        if (ar_fire) issued <= issued + 1'b1;
        if (xi_fire) delivered <= delivered + 1'b1;
      end
      credit <= credit + CW'(ar_fire) - CW'(xi_fire);
      dcnt <= dcnt + CW'(r_fire) - CW'(xi_fire);
      if (ar_fire) owr <= nxt(owr);
      if (r_fire) ord <= nxt(ord);
      if (r_fire) dwr <= nxt(dwr);
      if (xi_fire) drd <= nxt(drd);
    end
  end
  always_ff @(posedge clk) begin
    if (ar_fire) ofs_mem[owr] <= bus.m_axi_araddr[2:0];
    if (r_fire) dat_mem[dwr] <= elem;
  end
`ifdef XI_GATHER_RESP_ERR_EN
  always_ff @(posedge clk) begin
    if (!rstn || start_ok) err <= 1'b0;
    else if (r_fire && bus.m_axi_rresp != 2'b00) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif
endmodule
